// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared control definitions for the multicycle core: controller state
//   encoding, RV32 base opcode constants, PC-source and trap-cause encodings,
//   and small opcode classification helpers. The decoder and immgen import the
//   same constants so every block agrees on one opcode map.
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  // Base-ISA opcodes (inst[6:0]) understood by this controller.
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    CAUSE_NONE         = 2'd0,
    CAUSE_ILLEGAL      = 2'd1,
    CAUSE_IMEM_TIMEOUT = 2'd2,
    CAUSE_DMEM_TIMEOUT = 2'd3
  } trap_cause_e;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_R, OP_I_ALU, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_LUI, OP_JAL: is_legal_opcode = 1'b1;
      default:                   is_legal_opcode = 1'b0;
    endcase
  endfunction

  // Operand B comes from the immediate generator for everything except
  // register-register ALU ops and branches (which compare two registers).
  function automatic logic uses_imm(input logic [6:0] op);
    uses_imm = !((op == OP_R) || (op == OP_BRANCH));
  endfunction

  function automatic logic is_mem_op(input logic [6:0] op);
    is_mem_op = (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage : multicycle_ctrl_pkg

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
//   Counts cycles spent waiting on a memory that has not signalled ready and
//   flags expiry on the TIMEOUT-th consecutive not-ready cycle. A ready in
//   that same cycle suppresses expiry.
//
//   Ports
//     clk     : clock, rising edge
//     rstn    : asynchronous active-low reset, clears the count
//     start   : synchronous clear; asserted in the cycle before a wait state
//               is entered so the count starts from zero
//     ready   : the memory being waited on is ready this cycle
//     expired : combinational; this is the last allowed not-ready cycle
// -----------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic ready,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;

  // NOTE: clocked state is written with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= '0;
    end else if (!ready && (count_q != CW'(TIMEOUT))) begin
      count_q <= count_q + CW'(1);
    end
  end

  // count_q holds the not-ready cycles already elapsed, so the current cycle
  // is number count_q+1.
  assign expired = !ready && (count_q == CW'(TIMEOUT - 1));

endmodule : mem_wait_timer

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM of a multicycle RV32 subset core:
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with an absorbing TRAP
//   state for illegal opcodes and memory timeouts. Control outputs are decodes
//   of the registered state (qualified by the handshake inputs valid in that
//   state), so they act in the same cycle the datapath needs them.
//
//   Ports
//     clk, rstn      : clock (rising edge), asynchronous active-low reset
//     inst           : instruction register contents, opcode in inst[6:0]
//     branch_taken   : branch comparator result, sampled in EXEC
//     imem_ready     : instruction memory has data this cycle
//     dmem_ready     : data memory completed the access this cycle
//     imem_req       : instruction fetch request
//     dmem_req       : data memory request; dmem_we qualifies it as a write
//     ir_we          : load instruction register
//     pc_we, pc_src  : PC update strobe and source (PC+4 / branch / jump)
//     reg_we         : register-file write enable
//     alu_src_imm    : ALU operand B from immgen
//     mem_to_reg     : writeback data from data memory
//     trap           : controller halted
//     trap_cause     : why it halted (held until reset)
//     instret        : retired-instruction count, +1 per pc_we
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] inst,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic        alu_src_imm,
  output logic        mem_to_reg,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  trap_cause_e cause_q, cause_d;
  logic [31:0] instret_q;

  logic [6:0] opcode;
  logic       unused_inst_bits;

  assign opcode           = inst[6:0];
  assign unused_inst_bits = ^inst[31:7];

  // Ungated decodes of the current state.
  logic    imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c;
  logic    reg_we_c, alu_src_imm_c, mem_to_reg_c;
  pc_src_e pc_src_c;

  logic wait_start, wait_ready, wait_expired;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rstn    (rstn),
    .start   (wait_start),
    .ready   (wait_ready),
    .expired (wait_expired)
  );

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    imem_req_c    = 1'b0;
    dmem_req_c    = 1'b0;
    dmem_we_c     = 1'b0;
    ir_we_c       = 1'b0;
    pc_we_c       = 1'b0;
    pc_src_c      = PC_PLUS4;
    reg_we_c      = 1'b0;
    alu_src_imm_c = 1'b0;
    mem_to_reg_c  = 1'b0;
    // Outside the two wait states the timer must not count.
    wait_ready    = 1'b1;

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        wait_ready = imem_ready;
        if (imem_ready) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IMEM_TIMEOUT;
        end
      end

      S_DECODE: begin
        if (is_legal_opcode(opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end

      S_EXEC: begin
        alu_src_imm_c = uses_imm(opcode);
        if (opcode == OP_BRANCH) begin
          // Branches retire here; no MEM or WB.
          pc_we_c  = 1'b1;
          pc_src_c = branch_taken ? PC_BRANCH : PC_PLUS4;
          state_d  = S_FETCH;
        end else if (is_mem_op(opcode)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (opcode == OP_STORE);
        wait_ready = dmem_ready;
        if (dmem_ready) begin
          if (opcode == OP_STORE) begin
            // Stores have nothing to write back and retire here.
            pc_we_c = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM_TIMEOUT;
        end
      end

      S_WB: begin
        reg_we_c     = 1'b1;
        pc_we_c      = 1'b1;
        mem_to_reg_c = (opcode == OP_LOAD);
        pc_src_c     = (opcode == OP_JAL) ? PC_JUMP : PC_PLUS4;
        state_d      = S_FETCH;
      end

      S_TRAP: begin
        // Absorbing: all strobes stay low, cause is held.
      end

      default: begin
        state_d = S_TRAP;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase

    // Clear the wait counter on every entry into a wait state.
    wait_start = ((state_d == S_FETCH) || (state_d == S_MEM)) &&
                 (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_FETCH;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (pc_we_c) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  // NOTE: the decodes also depend on live handshake inputs, so they are
  // qualified with rstn; while reset is held nothing is requested or written,
  // and imem_req rises as soon as reset is released (state is already FETCH).
  assign imem_req    = rstn & imem_req_c;
  assign dmem_req    = rstn & dmem_req_c;
  assign dmem_we     = rstn & dmem_we_c;
  assign ir_we       = rstn & ir_we_c;
  assign pc_we       = rstn & pc_we_c;
  assign pc_src      = rstn ? pc_src_c : PC_PLUS4;
  assign reg_we      = rstn & reg_we_c;
  assign alu_src_imm = rstn & alu_src_imm_c;
  assign mem_to_reg  = rstn & mem_to_reg_c;
  assign trap        = rstn & (state_q == S_TRAP);
  assign trap_cause  = cause_q;
  assign instret     = instret_q;

endmodule : multicycle_ctrl
